pcm_uart_bridge: RTL and testbench
==================================

# pcm_uart_bridge

Buffers 8-bit PCM samples from the microphone PDM-to-PCM stage and serialises them over a UART 8N1 link to the host. The block sits directly downstream of the mic decimator. It accepts that stage's one-cycle `data_ready` strobe plus its 8-bit sample, holds samples in a small FIFO, and drives the board's FTDI TX pin. The FIFO absorbs rate mismatch and short stalls; sustained overrun is flagged, not hidden.

## Interface
- `DIV`, 16: clock cycles per UART bit; legal range 2..65535.
- `DEPTH_LOG2`, 4: FIFO depth = 2^DEPTH_LOG2 entries.
- `clk` in 1: single system clock; every register in the block is clocked by it.
- `rst` in 1: synchronous, active-low reset, sampled on rising `clk`.
- `data_ready` in 1: one-cycle sample strobe from the upstream stage.
- `data_in` in 8: PCM sample, valid only while `data_ready` = 1.
- `uart_tx` out 1: serial output; idles high.
- `fifo_level` out DEPTH_LOG2+1: current FIFO occupancy, 0..2^DEPTH_LOG2.
- `overflow` out 1: sticky flag; set when a sample is dropped.
- `busy` out 1: high while a frame is on the wire.

## Operation
- Reset (`rst` = 0 at an edge):
  - `uart_tx` = 1, `fifo_level` = 0, `overflow` = 0, `busy` = 0.
  - FIFO pointers are cleared and the FSM goes to IDLE.
  - A frame in progress is abandoned immediately; no completion of the stop bit.
- Push: `data_ready` = 1 writes `data_in` if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the sample is dropped and `overflow` is set to 1. It stays at 1 until reset.
- Pop: happens when the FSM is in IDLE, or at the last cycle of STOP, and the FIFO is non-empty.
- Push and pop in the same cycle leave `fifo_level` unchanged. This holds at both the full and the empty boundary: push into an empty FIFO is not bypassed; the pop occurs on the following cycle.
- FSM states: IDLE → START → DATA → STOP → (IDLE or START).
  - START: `uart_tx` = 0 for DIV cycles.
  - DATA: bits 0..7 sent LSB-first, DIV cycles each. A 3-bit index counts the bits; a bit-timer counts cycles 0..DIV-1.
  - STOP: `uart_tx` = 1 for DIV cycles. On its last cycle the FSM pops and enters START if the FIFO is non-empty, otherwise it enters IDLE.
- `busy` = 1 in START, DATA and STOP; 0 in IDLE.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. `fifo_level` is a separate counter, so full and empty are unambiguous.

## Timing
- All outputs are registered.
- Latency: a push at edge k, with the FIFO empty and the FSM in IDLE, leads to a pop at edge k+1. `uart_tx` falls after edge k+1.
- Frame length: exactly 10·DIV cycles.
- Back-to-back frames have zero idle gap: the next start bit begins the cycle after the last stop-bit cycle.
- `fifo_level` updates on the edge following a push or pop.
- `overflow` rises on the edge after the dropped `data_ready`.
- Sustained throughput: one sample per 10·DIV cycles. With the upstream stage producing one sample per 256 mic clocks, DIV must satisfy 10·DIV ≤ 256·(clk/mic_clk) for no overflow.

## Configuration
- `PCM_UART_FRAMING_EN`
  - Defined:
    - Before every 32nd sample popped (the first sample after reset included), the FSM sends a header byte 0xFF.
    - The header is not taken from the FIFO; the FSM sends it, then pops the sample.
    - Payload samples equal to 0xFF are sent as 0xFE, so 0xFF is unique to headers.
    - A 5-bit sample counter is added; reset clears it.
  - Undefined: raw samples only, no header, no clipping.

## Test plan
- Reset with DIV=4: `uart_tx`=1, `fifo_level`=0, `overflow`=0, `busy`=0. Single push of 0x5A → `uart_tx` falls one cycle later; line pattern 0,0,1,0,1,1,0,1,0,1, 4 cycles per bit; `busy` low after 40 cycles.
- Burst of 3 pushes (0x01, 0x80, 0xFF) on consecutive cycles → three frames back-to-back, 120 cycles total, no idle gap; `fifo_level` peaks at 2.
- With DEPTH_LOG2=2 and the TX busy, push 6 samples → `fifo_level` = 4 and `overflow` = 1; exactly the first 5 samples are transmitted (1 in flight + 4 buffered).
- Push while full in the same cycle as a stop-bit pop → sample accepted, `fifo_level` stays 4, `overflow` unchanged.
- Assert `rst`=0 mid-DATA → next cycle `uart_tx`=1, `busy`=0, `fifo_level`=0. A push after release transmits normally.
- With `PCM_UART_FRAMING_EN` defined, push 0xFF then 33 × 0x10 → line carries 0xFF, 0xFE, 31 × 0x10, 0xFF, 0x10, 0x10.

Source files
------------

// File: rtl/pcm_uart_bridge.sv
// -----------------------------------------------------------------------------
// pcm_uart_bridge
//
// Buffers 8-bit PCM samples from the mic decimator in a small FIFO and
// serialises them over a UART 8N1 link (LSB first, one start bit, one stop
// bit). Frames run back-to-back with no idle gap while the FIFO holds data.
//
// Parameters:
//   DIV        : clock cycles per UART bit (2..65535)
//   DEPTH_LOG2 : FIFO depth is 2**DEPTH_LOG2 entries
//
// Ports:
//   clk        in  : system clock
//   rst        in  : synchronous active-low reset
//   data_ready in  : one-cycle sample strobe from the decimator
//   data_in    in  : 8-bit PCM sample, valid with data_ready
//   uart_tx    out : serial line, idles high (registered)
//   fifo_level out : FIFO occupancy 0..2**DEPTH_LOG2 (registered)
//   overflow   out : sticky, set when a sample is dropped (registered)
//   busy       out : high while a frame is on the wire (registered)
//
// Optional feature (macro PCM_UART_FRAMING_EN):
//   When defined, a 0xFF header frame precedes every 32nd sample popped
//   (starting with the first after reset), and payload 0xFF is sent as 0xFE.
// -----------------------------------------------------------------------------
module pcm_uart_bridge #(
  parameter int DIV        = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_ready,
  input  logic [7:0]            data_in,
  output logic                  uart_tx,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic                  busy
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [15:0]         DIV_LAST   = 16'(DIV - 1);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FSM and shifter registers
  state_t                r_state;
  logic [15:0]           r_timer;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_byte;

  // FIFO storage and bookkeeping
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;

  // Registered line outputs
  logic                  r_tx;
  logic                  r_busy;

  // Combinational next-state / control
  state_t                w_state_nxt;
  logic [15:0]           w_timer_nxt;
  logic [2:0]            w_idx_nxt;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_bit_last;
  logic                  w_launch;
  logic                  w_send_hdr;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [7:0]            w_head;
  logic [7:0]            w_load_byte;

`ifdef PCM_UART_FRAMING_EN
  logic [4:0]            r_samp_cnt;
  logic                  r_hdr_sent;
`endif

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LEVEL_FULL);
  assign w_bit_last = (r_timer == DIV_LAST);
  assign w_head     = r_mem[r_rd_ptr];

  // A new frame may start from IDLE or on the final stop-bit cycle, but only
  // when the FIFO already holds data (a same-cycle push is never bypassed).
  assign w_launch = ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_last)) && !w_empty;

`ifdef PCM_UART_FRAMING_EN
  // The header frame uses a launch slot without consuming a FIFO entry; the
  // sample it announces is popped at the following launch.
  assign w_send_hdr  = w_launch && (r_samp_cnt == 5'd0) && !r_hdr_sent;
  assign w_pop       = w_launch && !w_send_hdr;
  assign w_load_byte = w_send_hdr ? 8'hFF : ((w_head == 8'hFF) ? 8'hFE : w_head);
`else
  assign w_send_hdr  = 1'b0;
  assign w_pop       = w_launch;
  assign w_load_byte = w_head;
`endif

  // A full FIFO still accepts a sample when an entry leaves in the same cycle.
  assign w_push = data_ready && (!w_full || w_pop);
  assign w_drop = data_ready && !w_push;

  // FSM state register together with the bit timer and bit index
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_timer   <= 16'd0;
      r_bit_idx <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_idx_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_bit_idx;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = 16'd0;
        w_idx_nxt   = 3'd0;
        if (w_launch) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_last) begin
          w_state_nxt = S_DATA;
          w_timer_nxt = 16'd0;
          w_idx_nxt   = 3'd0;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_last) begin
          w_timer_nxt = 16'd0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_idx_nxt   = 3'd0;
          end else begin
            w_idx_nxt   = r_bit_idx + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_last) begin
          w_timer_nxt = 16'd0;
          if (w_launch) begin
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = 16'd0;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // FSM output logic, decoded from the next state so the registered line
  // level lines up with the state it belongs to
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
      end
      S_START: begin
        w_tx_nxt   = 1'b0;
        w_busy_nxt = 1'b1;
      end
      S_DATA: begin
        w_tx_nxt   = r_byte[w_idx_nxt];
        w_busy_nxt = 1'b1;
      end
      S_STOP: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
      end
      default: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Output registers and the byte being shifted out
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_byte <= 8'h00;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
      if (w_launch) begin
        r_byte <= w_load_byte;
      end else begin
        r_byte <= r_byte;
      end
    end
  end

  // FIFO storage; contents need no reset since the level gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef PCM_UART_FRAMING_EN
  // Header bookkeeping: counts popped samples modulo 32
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_samp_cnt <= 5'd0;
      r_hdr_sent <= 1'b0;
    end else if (w_send_hdr) begin
      r_hdr_sent <= 1'b1;
    end else if (w_pop) begin
      r_hdr_sent <= 1'b0;
      r_samp_cnt <= r_samp_cnt + 5'd1;
    end
  end
`endif

  assign uart_tx    = r_tx;
  assign busy       = r_busy;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pcm_uart_bridge.sv
// Directed bench for pcm_uart_bridge with DIV=4 and a 4-entry FIFO.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pcm_uart_bridge;

  localparam int DIV = 4;
  localparam int DL2 = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           data_ready;
  logic [7:0]     data_in;
  logic           uart_tx;
  logic [DL2:0]   fifo_level;
  logic           overflow;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pcm_uart_bridge #(.DIV(DIV), .DEPTH_LOG2(DL2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_ready (data_ready),
    .data_in    (data_in),
    .uart_tx    (uart_tx),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .busy       (busy)
  );

  // Expected 40-cycle line image of one frame: start, 8 data bits LSB first, stop.
  function automatic logic [39:0] exp_frame(input logic [7:0] b);
    logic [9:0]  bits;
    logic [39:0] f;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) f[i] = bits[i / DIV];
    return f;
  endfunction

  // Samples the line on the next 40 falling edges.
  task automatic capture_frame(output logic [39:0] v, output logic all_busy);
    all_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      v[i] = uart_tx;
      if (busy !== 1'b1) all_busy = 1'b0;
    end
  endtask

  // Waits for a start bit (bounded) and decodes one byte at mid-bit points.
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int w;
    w = 0; ok = 1'b1; b = 8'h00;
    while (uart_tx !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      ok = 1'b0;
    end else begin
      repeat (6) @(negedge clk);
      b[0] = uart_tx;
      for (int i = 1; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (4) @(negedge clk);
      if (uart_tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] v);
    data_ready = 1'b1;
    data_in    = v;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    data_ready = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data_ready = 1'b1;
    data_in = 8'h77;
    repeat (3) @(negedge clk);
    n_checks++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx); else n_pass++;
    n_checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    data_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [39:0] f;
    logic ab;
    push(8'h5A);
    n_checks++; if (fifo_level !== 3'd1) $display("FAIL single_level: got %0d want 1", fifo_level); else n_pass++;
    n_checks++; if (uart_tx !== 1'b1) $display("FAIL single_no_bypass: got %b want 1", uart_tx); else n_pass++;
    capture_frame(f, ab);
    n_checks++; if (f !== exp_frame(8'h5A)) $display("FAIL single_frame: got %h want %h", f, exp_frame(8'h5A)); else n_pass++;
    n_checks++; if (ab !== 1'b1) $display("FAIL single_busy: got %b want 1", ab); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++; if (uart_tx !== 1'b1) $display("FAIL single_idle_tx: got %b want 1", uart_tx); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [39:0] f [3];
    logic        ab [3];
    logic [7:0]  e [3];
    e[0] = 8'h01; e[1] = 8'h80; e[2] = 8'hFF;
    data_ready = 1'b1; data_in = e[0];
    @(negedge clk);
    data_in = e[1];
    n_checks++; if (fifo_level !== 3'd1) $display("FAIL burst_level1: got %0d want 1", fifo_level); else n_pass++;
    fork
      for (int i = 0; i < 3; i++) capture_frame(f[i], ab[i]);
      begin
        @(negedge clk);
        data_in = e[2];
        @(negedge clk);
        data_ready = 1'b0;
        n_checks++; if (fifo_level !== 3'd2) $display("FAIL burst_peak: got %0d want 2", fifo_level); else n_pass++;
      end
    join
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (f[i] !== exp_frame(e[i]) || ab[i] !== 1'b1)
        $display("FAIL burst_frame%0d: got %h busy %b want %h busy 1", i, f[i], ab[i], exp_frame(e[i]));
      else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || fifo_level !== 3'd0) $display("FAIL burst_end: got busy %b level %0d want 0 0", busy, fifo_level); else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [39:0] f [6];
    logic        ab [6];
    do_reset();
    data_ready = 1'b1; data_in = 8'hA0;
    @(negedge clk);
    data_in = 8'hA1;
    fork
      for (int i = 0; i < 6; i++) capture_frame(f[i], ab[i]);
      begin
        @(negedge clk); data_in = 8'hA2;
        @(negedge clk); data_in = 8'hA3;
        @(negedge clk); data_in = 8'hA4;
        @(negedge clk); data_ready = 1'b0;
        n_checks++; if (fifo_level !== 3'd4) $display("FAIL fullpop_full: got %0d want 4", fifo_level); else n_pass++;
        repeat (36) @(negedge clk);
        data_ready = 1'b1; data_in = 8'hA5;
        @(negedge clk);
        data_ready = 1'b0;
        n_checks++; if (fifo_level !== 3'd4) $display("FAIL fullpop_level: got %0d want 4", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b want 0", overflow); else n_pass++;
      end
    join
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (f[i] !== exp_frame(8'hA0 + 8'(i)))
        $display("FAIL fullpop_frame%0d: got %h want %h", i, f[i], exp_frame(8'hA0 + 8'(i)));
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [39:0] f [5];
    logic        ab [5];
    logic        seen;
    logic [7:0]  s [6];
    s[0] = 8'h11; s[1] = 8'h22; s[2] = 8'h33; s[3] = 8'h44; s[4] = 8'h55; s[5] = 8'h66;
    do_reset();
    data_ready = 1'b1; data_in = s[0];
    @(negedge clk);
    data_in = s[1];
    fork
      for (int i = 0; i < 5; i++) capture_frame(f[i], ab[i]);
      begin
        for (int i = 2; i < 6; i++) begin
          @(negedge clk);
          data_in = s[i];
        end
        @(negedge clk);
        data_ready = 1'b0;
        n_checks++; if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d want 4", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
      end
    join
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (f[i] !== exp_frame(s[i])) $display("FAIL ovf_frame%0d: got %h want %h", i, f[i], exp_frame(s[i]));
      else n_pass++;
    end
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL ovf_extra_frame: got activity %b want 0", seen); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [39:0] f;
    logic ab;
    do_reset();
    push(8'h3C);
    push(8'h99);
    repeat (9) @(negedge clk);
    n_checks++; if (uart_tx !== 1'b0 || busy !== 1'b1) $display("FAIL mid_pre: got tx %b busy %b want 0 1", uart_tx, busy); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (uart_tx !== 1'b1) $display("FAIL mid_tx: got %b want 1", uart_tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (fifo_level !== 3'd0) $display("FAIL mid_level: got %0d want 0", fifo_level); else n_pass++;
    @(negedge clk);
    push(8'hC3);
    capture_frame(f, ab);
    n_checks++; if (f !== exp_frame(8'hC3)) $display("FAIL mid_after: got %h want %h", f, exp_frame(8'hC3)); else n_pass++;
  endtask

  task automatic test_framing();
    logic [7:0] e [36];
    logic [7:0] b;
    logic       ok;
    for (int j = 0; j < 36; j++) e[j] = 8'h10;
    e[0] = 8'hFF; e[1] = 8'hFE; e[33] = 8'hFF;
    do_reset();
    fork
      for (int i = 0; i < 34; i++) begin
        int w;
        w = 0;
        while (fifo_level >= 3'd4 && w < 5000) begin
          @(negedge clk);
          w++;
        end
        push((i == 0) ? 8'hFF : 8'h10);
      end
      for (int j = 0; j < 36; j++) begin
        rx_byte(b, ok);
        n_checks++;
        if (ok !== 1'b1 || b !== e[j]) $display("FAIL frm_byte%0d: got %h ok %b want %h", j, b, ok, e[j]);
        else n_pass++;
      end
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    data_ready = 1'b0;
    data_in = 8'h00;
    @(negedge clk);
    test_reset();
`ifdef PCM_UART_FRAMING_EN
    test_framing();
`else
    test_single();
    test_back_to_back();
    test_full_pop();
    test_overflow();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
